// File: rtl/mc_controller_if.sv
// rtl/mc_controller_if.sv - instruction-field inputs and datapath control bundle for mc_controller
interface mc_controller_if;
   logic [3:0] Op;
   logic [8:0] Func;
   logic       Zero;
   logic       AdrSrc;
   logic       MemWrite;
   logic       IRWrite;
   logic       RegWrite;
   logic       A3Src;
   logic       PCWrite;
   logic       OldPCWrite;
   logic       MDRWrite;
   logic       ResultSrc;
   logic       AWrite;
   logic       BWrite;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ImmSrc;
   logic [2:0] ALUControl;
   logic [1:0] PCSrc;

   modport master (
      input  Op, Func, Zero,
      output AdrSrc, MemWrite, IRWrite, RegWrite, A3Src, PCWrite, OldPCWrite,
             MDRWrite, ResultSrc, AWrite, BWrite, ALUSrcA, ALUSrcB, ImmSrc,
             ALUControl, PCSrc
   );

   modport slave (
      output Op, Func, Zero,
      input  AdrSrc, MemWrite, IRWrite, RegWrite, A3Src, PCWrite, OldPCWrite,
             MDRWrite, ResultSrc, AWrite, BWrite, ALUSrcA, ALUSrcB, ImmSrc,
             ALUControl, PCSrc
   );
endinterface

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle Moore control FSM for the accumulator datapath; MC_CTRL_HALT_EN adds the HALT state
module mc_controller #(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   mc_controller_if.master    bus,
   output logic               halted,
   output logic [STATE_W-1:0] state
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEM_RD  = 4'd2,
      S_LOAD_WB = 4'd3,
      S_MEM_WR  = 4'd4,
      S_JMP     = 4'd5,
      S_BR_EVAL = 4'd6,
      S_EXEC_C  = 4'd7,
      S_EXEC_I  = 4'd8,
`ifdef MC_CTRL_HALT_EN
      S_HALT    = 4'd10,
`endif
      S_ALU_WB  = 4'd9
   } state_t;

   state_t     r_state;
   state_t     w_next;
   logic       w_c_valid;
   logic [2:0] w_c_alu;
   logic       w_adr, w_memw, w_irw, w_regw, w_a3, w_pcw, w_oldpc, w_mdr, w_res, w_aw, w_bw;
   logic [1:0] w_srca, w_srcb, w_pcsrc;
   logic [2:0] w_alu;

   // Type-C ops are valid only with a single Func bit set, and that bit in [6:0].
   assign w_c_valid = (bus.Func[8:7] == 2'b00) && $onehot(bus.Func[6:0]);

   always_comb begin
      w_c_alu = 3'b000;
      if (bus.Func[0])      w_c_alu = 3'b101;
      else if (bus.Func[1]) w_c_alu = 3'b110;
      else if (bus.Func[2]) w_c_alu = 3'b000;
      else if (bus.Func[3]) w_c_alu = 3'b001;
      else if (bus.Func[4]) w_c_alu = 3'b010;
      else if (bus.Func[5]) w_c_alu = 3'b011;
      else if (bus.Func[6]) w_c_alu = 3'b100;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_FETCH;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      w_adr   = 1'b0;
      w_memw  = 1'b0;
      w_irw   = 1'b0;
      w_regw  = 1'b0;
      w_a3    = 1'b0;
      w_pcw   = 1'b0;
      w_oldpc = 1'b0;
      w_mdr   = 1'b0;
      w_res   = 1'b0;
      w_aw    = 1'b0;
      w_bw    = 1'b0;
      w_srca  = 2'b00;
      w_srcb  = 2'b00;
      w_pcsrc = 2'b00;
      w_alu   = 3'b000;
      case (r_state)
         S_FETCH: begin
            w_irw = 1'b1; w_oldpc = 1'b1; w_pcw = 1'b1; w_srcb = 2'b01;
            w_next = S_DECODE;
         end
         S_DECODE: begin
            w_aw = 1'b1; w_bw = 1'b1;
            case (bus.Op)
               4'b0000: w_next = S_MEM_RD;
               4'b0001: w_next = S_MEM_WR;
               4'b0010: w_next = S_JMP;
               4'b0100: w_next = S_BR_EVAL;
               4'b1000: w_next = w_c_valid ? S_EXEC_C : S_FETCH;
               4'b1100, 4'b1101, 4'b1110, 4'b1111: w_next = S_EXEC_I;
`ifdef MC_CTRL_HALT_EN
               4'b0011: w_next = S_HALT;
`endif
               default: w_next = S_FETCH;
            endcase
         end
         S_MEM_RD:  begin w_adr = 1'b1; w_mdr = 1'b1; w_next = S_LOAD_WB; end
         S_LOAD_WB: begin w_res = 1'b1; w_regw = 1'b1; w_next = S_FETCH; end
         S_MEM_WR:  begin w_adr = 1'b1; w_memw = 1'b1; w_next = S_FETCH; end
         S_JMP:     begin w_pcsrc = 2'b01; w_pcw = 1'b1; w_next = S_FETCH; end
         S_BR_EVAL: begin
            w_srca = 2'b10; w_alu = 3'b101; w_pcsrc = 2'b10; w_pcw = bus.Zero;
            w_next = S_FETCH;
         end
         S_EXEC_C:  begin w_srca = 2'b10; w_alu = w_c_alu; w_next = S_ALU_WB; end
         S_EXEC_I:  begin
            w_srca = 2'b10; w_srcb = 2'b10; w_alu = {1'b0, bus.Op[1:0]};
            w_next = S_ALU_WB;
         end
         S_ALU_WB:  begin
            // MOVETO writes Ri from R0; every other op writes back to R0.
            w_regw = 1'b1;
            w_a3   = (bus.Op == 4'b1000) && bus.Func[0];
            w_next = S_FETCH;
         end
`ifdef MC_CTRL_HALT_EN
         S_HALT:    w_next = S_HALT;
`endif
         default:   w_next = S_FETCH;
      endcase
   end

   assign bus.AdrSrc     = reset & w_adr;
   assign bus.MemWrite   = reset & w_memw;
   assign bus.IRWrite    = reset & w_irw;
   assign bus.RegWrite   = reset & w_regw;
   assign bus.A3Src      = reset & w_a3;
   assign bus.PCWrite    = reset & w_pcw;
   assign bus.OldPCWrite = reset & w_oldpc;
   assign bus.MDRWrite   = reset & w_mdr;
   assign bus.ResultSrc  = reset & w_res;
   assign bus.AWrite     = reset & w_aw;
   assign bus.BWrite     = reset & w_bw;
   assign bus.ALUSrcA    = reset ? w_srca  : 2'b00;
   assign bus.ALUSrcB    = reset ? w_srcb  : 2'b00;
   assign bus.ImmSrc     = 2'b00;
   assign bus.ALUControl = reset ? w_alu   : 3'b000;
   assign bus.PCSrc      = reset ? w_pcsrc : 2'b00;
   assign state          = reset ? STATE_W'(r_state) : '0;
`ifdef MC_CTRL_HALT_EN
   assign halted         = reset && (r_state == S_HALT);
`else
   assign halted         = 1'b0;
`endif

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
Multicycle control unit that drives the accumulator datapath's control inputs. It decodes Op, Func and Zero, and sequences fetch, decode, memory, ALU and writeback cycles with a Moore FSM. R0 is the accumulator (RF read port 1 hard-wired to R0), and Ri is selected by Instr[11:9]. The datapath's ALU-output register loads unconditionally every cycle.

Parameters:
STATE_W, 4, width of the state debug output (must be >= 4)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
Op  input  4  Instr[15:12]
Func  input  9  Instr[8:0]; one-hot for type-C ops
Zero  input  1  ALU zero flag (combinational, same cycle)
AdrSrc, MemWrite, IRWrite, RegWrite, A3Src, PCWrite, OldPCWrite, MDRWrite, ResultSrc, AWrite, BWrite  output  1 each  datapath controls
ALUSrcA  output  2  00 PC, 01 OldPC, 10 A
ALUSrcB  output  2  00 B, 01 constant 1, 10 ImmExt
ImmSrc  output  2  00 = sign-extend Instr[11:0]; only value ever driven
ALUControl  output  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOT In1, 101 PASS In1, 110 PASS In2
PCSrc  output  2  00 ALUResult, 01 jump, 10 branch
halted  output  1  high in HALT state
state  output  STATE_W  current state code (debug)

Behaviour:
- Reset handling:
  - While reset=0, every output is 0 and the state is FETCH.
  - The first active edge after release executes FETCH.
  - Reset mid-instruction abandons the instruction; no further writes occur.
- Outputs are Moore, except PCWrite in BR_EVAL (= Zero).
- Default for every control not listed in a state: 0 / 00 / 000.
- FETCH: IRWrite=1, OldPCWrite=1, PCWrite=1, PCSrc=00, ALUSrcA=00, ALUSrcB=01, ALUControl=ADD. Next state: DECODE.
- DECODE: AWrite=1, BWrite=1. Next state by Op:
  - 0000 LOAD -> MEM_RD
  - 0001 STORE -> MEM_WR
  - 0010 JUMP -> JMP
  - 0100 BZ -> BR_EVAL
  - 1000 type-C -> EXEC_C, if Func is exactly one-hot in bits[6:0]; otherwise -> FETCH (NOP)
  - 1100 ADDI / 1101 SUBI / 1110 ANDI / 1111 ORI -> EXEC_I
  - any other Op -> FETCH (NOP)
- MEM_RD: AdrSrc=1, MDRWrite=1. Next state: LOAD_WB.
- LOAD_WB: ResultSrc=1, A3Src=0, RegWrite=1 (R0 <- Mem). Next state: FETCH.
- MEM_WR: AdrSrc=1, MemWrite=1 (Mem[Instr[11:0]] <- A). Next state: FETCH.
- JMP: PCSrc=01, PCWrite=1. Next state: FETCH.
- BR_EVAL: ALUSrcA=10, ALUControl=PASS In1, PCSrc=10, PCWrite=Zero. Next state: FETCH.
- EXEC_C: ALUSrcA=10, ALUSrcB=00. ALUControl by Func bit:
  - bit0 MOVETO: PASS In1
  - bit1 MOVEFROM: PASS In2
  - bit2: ADD
  - bit3: SUB
  - bit4: AND
  - bit5: OR
  - bit6: NOT
  Next state: ALU_WB.
- EXEC_I: ALUSrcA=10, ALUSrcB=10, ImmSrc=00, ALUControl={1'b0, Op[1:0]}. Next state: ALU_WB.
- ALU_WB: ResultSrc=0, RegWrite=1. A3Src=1 only when the decoded op is MOVETO (Ri <- R0); otherwise A3Src=0 (R0 <- result). Next state: FETCH.
- Latency, cycles per instruction:
  - LOAD 4
  - STORE 3, JMP 3, BZ 3
  - type-C 4, imm 4
  - NOP 2
- Op and Func are read directly from the live IR, which is stable after FETCH. The FSM latches no instruction bits.
- Func bit7 (NOP) and bit8 are treated as NOP.
- More than one Func bit set in [6:0] is treated as NOP.

Optional Feature:
MC_CTRL_HALT_EN.
- Defined:
  - Op 0011 in DECODE -> HALT.
  - HALT drives all controls 0 and halted=1, and remains until reset=0.
- Undefined:
  - Op 0011 is a NOP.
  - halted is tied 0.
  - The HALT state does not exist.

Test Plan:
- reset=0 for 3 cycles, then release -> all outputs 0 during reset; first post-release cycle shows FETCH with IRWrite=1, PCWrite=1, ALUSrcB=01.
- Op=0000 -> states FETCH, DECODE, MEM_RD, LOAD_WB; MDRWrite=1 in cycle 3; RegWrite=1, ResultSrc=1, A3Src=0 in cycle 4; back to FETCH in cycle 5.
- Op=0100 with Zero=1, then a second BZ with Zero=0 -> PCWrite=1, PCSrc=10 in BR_EVAL for the first; PCWrite=0 for the second; both take 3 cycles.
- Op=1000: Func=9'h001 -> ALU_WB has A3Src=1, ALUControl=101 in EXEC_C; Func=9'h004 -> ALUControl=000, A3Src=0; Func=9'h005 -> NOP, FETCH after DECODE.
- Op=1101 -> EXEC_I has ALUSrcB=10, ImmSrc=00, ALUControl=001; RegWrite=1 in the next cycle.
- Op=0011 with macro defined -> halted=1 held for 10 cycles, MemWrite/RegWrite/PCWrite stay 0, reset clears it. Without the macro -> 2-cycle NOP.
